// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks: cell colours,
// directions, grid size and the apple spawner state encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    off    = 2'b00,
    green  = 2'b01,
    red    = 2'b10,
    orange = 2'b11
  } cellStateColor;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } inputDirection;

  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    WRITE = 2'b10
  } spawner_state_t;

  // Fibonacci step, taps 16,14,13,11 (bit 0 is the oldest bit shifted out)
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shared source of pseudo-random values.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= SEED;
    else        out <= lfsr16_next(out);
  end

endmodule

// File: rtl/apple_spawner.sv
// Places apples into free grid cells (random start + linear probe) and keeps
// the score; requests arriving mid-search are remembered as one pending spawn.
module apple_spawner
  import snake_pkg::*;
#(
  parameter int          ROWS    = GRID_ROWS,
  parameter int          COLS    = GRID_COLS,
  parameter int          SCORE_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     eat_apple,
  input  logic                     game_over,
  output logic [$clog2(ROWS)-1:0]  rd_row,
  output logic [$clog2(COLS)-1:0]  rd_col,
  input  logic [1:0]               rd_cell,
  output logic                     wr_en,
  output logic [$clog2(ROWS)-1:0]  wr_row,
  output logic [$clog2(COLS)-1:0]  wr_col,
  output logic [1:0]               wr_cell,
  output logic [$clog2(ROWS)-1:0]  apple_row,
  output logic [$clog2(COLS)-1:0]  apple_col,
  output logic                     apple_valid,
  output logic [SCORE_W-1:0]       score,
  output logic                     busy,
  output logic                     no_space
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int IDX_W = ROW_W + COL_W;

  spawner_state_t   state;
  logic [15:0]      rnd;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] probe_cnt;
  logic             pending;
  logic             trigger;
  logic             cell_free;
  logic             last_probe;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (rnd)
  );

  generate
    if (IDX_W < 16) begin : g_rnd_tap
      logic unused_rnd;
      assign unused_rnd = ^rnd[15:IDX_W];
    end
  endgenerate

  assign trigger    = !game_over && ((start && !apple_valid) || eat_apple || pending);
  assign cell_free  = (rd_cell == off);
  // Power-of-two grid: all-ones count means every cell has been probed
  assign last_probe = &probe_cnt;

  assign {rd_row, rd_col} = idx;
  assign busy             = (state != IDLE);
  assign wr_cell          = wr_en ? red : off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       score <= '0;
    else if (eat_apple && !game_over && !(&score)) score <= score + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      probe_cnt   <= '0;
      pending     <= 1'b0;
      wr_en       <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      apple_row   <= '0;
      apple_col   <= '0;
      apple_valid <= 1'b0;
      no_space    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (game_over)                        pending <= 1'b0;
      else if (eat_apple && state != IDLE)  pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            idx       <= rnd[IDX_W-1:0];
            probe_cnt <= '0;
            pending   <= 1'b0;
            state     <= PROBE;
            if (eat_apple || pending) apple_valid <= 1'b0;
          end
        end
        PROBE: begin
          if (game_over) begin
            state <= IDLE;
          end else if (cell_free) begin
            wr_en            <= 1'b1;
            {wr_row, wr_col} <= idx;
            state            <= WRITE;
          end else if (last_probe) begin
            no_space <= 1'b1;
            state    <= IDLE;
          end else begin
            idx       <= idx + 1'b1;
            probe_cnt <= probe_cnt + 1'b1;
          end
        end
        WRITE: begin
          {apple_row, apple_col} <= idx;
          apple_valid            <= 1'b1;
          no_space               <= 1'b0;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner against a behavioural grid and an
// independent LFSR reference used to aim the random candidate.
module tb_apple_spawner;
  import snake_pkg::*;

  logic       clk = 1'b0, reset = 1'b0;
  logic       start = 1'b0, eat_apple = 1'b0, game_over = 1'b0, eat2 = 1'b0;
  logic [3:0] rd_row, rd_col, wr_row, wr_col, apple_row, apple_col;
  logic [1:0] rd_cell, wr_cell;
  logic       wr_en, apple_valid, busy, no_space;
  logic [7:0] score;

  logic [3:0] unused_rd_row, unused_rd_col, unused_wr_row, unused_wr_col;
  logic [3:0] unused_ap_row, unused_ap_col;
  logic [1:0] unused_wr_cell, score2;
  logic       unused_wr_en, unused_av, unused_busy, unused_ns;

  logic [1:0]  grid [256];
  logic [15:0] m;
  int          vectors = 0, miscompares = 0;

  assign rd_cell = grid[{rd_row, rd_col}];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) m <= 16'hACE1;
    else        m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};

  apple_spawner #(.ROWS(16), .COLS(16), .SCORE_W(8), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .eat_apple(eat_apple),
    .game_over(game_over), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_cell(wr_cell),
    .apple_row(apple_row), .apple_col(apple_col), .apple_valid(apple_valid),
    .score(score), .busy(busy), .no_space(no_space)
  );

  apple_spawner #(.ROWS(16), .COLS(16), .SCORE_W(2), .SEED(16'hACE1)) dut_sat (
    .clk(clk), .reset(reset), .start(1'b0), .eat_apple(eat2),
    .game_over(1'b0), .rd_row(unused_rd_row), .rd_col(unused_rd_col),
    .rd_cell(2'b00), .wr_en(unused_wr_en), .wr_row(unused_wr_row),
    .wr_col(unused_wr_col), .wr_cell(unused_wr_cell), .apple_row(unused_ap_row),
    .apple_col(unused_ap_col), .apple_valid(unused_av), .score(score2),
    .busy(unused_busy), .no_space(unused_ns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_eat();
    eat_apple = 1'b1; tick(); eat_apple = 1'b0;
  endtask

  task automatic wait_cand(input logic [7:0] c, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (m[7:0] == c) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Negedges from the trigger edge until wr_en is seen; -1 if never
  task automatic wait_wr(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (wr_en) begin cyc = i; break; end
    end
  endtask

  task automatic fill(input logic [1:0] v);
    for (int i = 0; i < 256; i++) grid[i] = v;
  endtask

  initial begin
    int         cyc, writes, busy_cyc;
    logic       ok;
    logic [7:0] c, first_addr;

    fill(off);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_apple_valid", apple_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", {rd_row, rd_col}, 0);
    chk("rst_no_space", no_space, 0);

    // First apple: candidate is the seed's low byte 0xE1
    reset = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("s1_busy", busy, 1);
    wait_wr(10, cyc);
    chk("s1_latency", cyc, 2);
    chk("s1_wr_addr", {wr_row, wr_col}, 8'hE1);
    chk("s1_wr_cell", wr_cell, 2'b10);
    grid[{wr_row, wr_col}] = red;
    @(negedge clk);
    chk("s1_wr_done", wr_en, 0);
    chk("s1_apple", {apple_valid, apple_row, apple_col}, 9'h1E1);
    chk("s1_score", score, 0);
    chk("s1_idle", busy, 0);

    // Candidate 0x20 with 0x20/0x21 occupied: two extra probes
    tick();
    wait_cand(8'h20, ok);
    chk("s2_cand_found", ok, 1);
    grid[8'h20] = orange; grid[8'h21] = orange;
    pulse_eat();
    wait_wr(20, cyc);
    chk("s2_latency", cyc, 4);
    chk("s2_wr_addr", {wr_row, wr_col}, 8'h22);
    grid[{wr_row, wr_col}] = red;
    @(negedge clk);
    chk("s2_score", score, 1);
    chk("s2_apple", {apple_valid, apple_row, apple_col}, 9'h122);

    // Candidate 0xFF occupied wraps to 0x00
    tick();
    wait_cand(8'hFF, ok);
    chk("s3_cand_found", ok, 1);
    grid[8'hFF] = orange;
    pulse_eat();
    wait_wr(20, cyc);
    chk("s3_latency", cyc, 3);
    chk("s3_wr_addr", {wr_row, wr_col}, 8'h00);
    grid[{wr_row, wr_col}] = red;
    @(negedge clk);
    chk("s3_score", score, 2);

    // Three spaced eats: each write lands on a free cell
    for (int k = 0; k < 3; k++) begin
      tick(); pulse_eat();
      wait_wr(20, cyc);
      chk("s4_wr_seen", wr_en, 1);
      chk("s4_wr_free", grid[{wr_row, wr_col}], 2'b00);
      grid[{wr_row, wr_col}] = red;
      repeat (6) @(negedge clk);
    end
    chk("s4_score", score, 5);

    // Narrow score saturates at 3
    for (int k = 0; k < 5; k++) begin
      tick(); eat2 = 1'b1; tick(); eat2 = 1'b0; tick();
      if (k == 2) begin @(negedge clk); chk("sat_score3", score2, 3); end
    end
    @(negedge clk);
    chk("sat_score5", score2, 3);

    // Full grid: 256 probes, no write
    fill(green);
    tick(); pulse_eat();
    busy_cyc = 0; writes = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (wr_en) writes++;
    end
    chk("s5_probe_cycles", busy_cyc, 256);
    chk("s5_writes", writes, 0);
    chk("s5_no_space", no_space, 1);
    chk("s5_apple_valid", apple_valid, 0);
    chk("s5_score", score, 6);

    // Two eats during a long probe: one pending search, two writes
    tick();
    c = m[7:0];
    first_addr = c + 8'd100;
    grid[first_addr] = off;
    grid[c + 8'd200] = off;
    pulse_eat();
    repeat (10) tick();
    pulse_eat();
    repeat (10) tick();
    pulse_eat();
    writes = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (wr_en) begin
        if (writes == 0) chk("s6_first_addr", {wr_row, wr_col}, first_addr);
        chk("s6_wr_free", grid[{wr_row, wr_col}], 2'b00);
        grid[{wr_row, wr_col}] = red;
        writes++;
      end
    end
    chk("s6_writes", writes, 2);
    chk("s6_score", score, 9);
    chk("s6_idle", busy, 0);
    chk("s6_no_space", no_space, 0);
    chk("s6_apple_valid", apple_valid, 1);

    // game_over mid-probe abandons the search
    tick();
    c = m[7:0];
    grid[c + 8'd150] = off;
    pulse_eat();
    repeat (20) tick();
    chk("s7_busy_before", busy, 1);
    game_over = 1'b1;
    tick();
    @(negedge clk);
    chk("s7_busy_after", busy, 0);
    writes = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en) writes++;
    end
    chk("s7_writes", writes, 0);
    tick(); pulse_eat();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("s7_score_frozen", score, 10);
    chk("s7_stay_idle", busy, 0);

    // Asynchronous reset mid-probe
    game_over = 1'b0;
    fill(green);
    tick();
    c = m[7:0];
    grid[c + 8'd150] = off;
    pulse_eat();
    repeat (10) tick();
    chk("s8_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("s8_rst_busy", busy, 0);
    chk("s8_rst_score", score, 0);
    chk("s8_rst_apple", {apple_valid, apple_row, apple_col}, 0);
    chk("s8_rst_wr", {wr_en, wr_row, wr_col}, 0);
    chk("s8_rst_rd_addr", {rd_row, rd_col}, 0);
    chk("s8_rst_no_space", no_space, 0);
    fill(off);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_wr(10, cyc);
    chk("s8_latency", cyc, 2);
    chk("s8_wr_addr", {wr_row, wr_col}, 8'hE1);
    @(negedge clk);
    chk("s8_apple", {apple_valid, apple_row, apple_col}, 9'h1E1);
    chk("s8_score", score, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apple_spawner.md
Name: apple_spawner

Overview:
- Writer-side counterpart to the collision detector, which reads grid cells and reports isEatApple/isGameOver.
- Places red (apple) cells into the game grid and keeps the score.
- Triggers: a `start` pulse for the first apple, or an `eat_apple` pulse from the collision detector.
- Picks a pseudo-random candidate cell from an LFSR and linear-probes the grid for an `off` cell. It then writes `red` through the grid write port.

Parameters:
- ROWS, 16, grid rows; must be a power of two.
- COLS, 16, grid columns; must be a power of two.
- SCORE_W, 8, score counter width.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- start  in  1  one-cycle pulse: spawn the first apple.
- eat_apple  in  1  one-cycle pulse from the collision detector (isEatApple).
- game_over  in  1  level from the collision detector (isGameOver).
- rd_row  out  log2(ROWS)  grid read row address.
- rd_col  out  log2(COLS)  grid read column address.
- rd_cell  in  2  cell colour at rd_row/rd_col; combinational, valid in the same cycle.
- wr_en  out  1  grid write strobe.
- wr_row  out  log2(ROWS)  grid write row address.
- wr_col  out  log2(COLS)  grid write column address.
- wr_cell  out  2  colour to write; always red (2'b10) when wr_en=1.
- apple_row  out  log2(ROWS)  row of the current apple.
- apple_col  out  log2(COLS)  column of the current apple.
- apple_valid  out  1  an apple is on the board.
- score  out  SCORE_W  apples eaten; saturates at all-ones.
- busy  out  1  high in any state other than IDLE.
- no_space  out  1  the last search found no `off` cell.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, LFSR = SEED, score = 0.
  - apple_valid = 0, no_space = 0, pending = 0, wr_en = 0.
  - All address outputs = 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle, including when idle or game_over.
  - Candidate index = low log2(ROWS*COLS) bits.
  - Index mapping: row = idx[MSBs], col = idx[LSBs].
- Trigger = (start && !apple_valid) || eat_apple.
- IDLE:
  - On trigger: idx <= LFSR candidate, probe_cnt <= 0, state <= PROBE.
  - eat_apple also clears apple_valid.
- PROBE:
  - rd_row/rd_col = idx.
  - If rd_cell == off (2'b00): state <= WRITE.
  - Else: idx <= idx+1, wrapping ROWS*COLS-1 -> 0, and probe_cnt <= probe_cnt+1.
  - If probe_cnt == ROWS*COLS-1 and the cell is occupied: no_space <= 1, state <= IDLE.
- WRITE (exactly one cycle):
  - wr_en = 1, wr_row/wr_col = idx, wr_cell = red.
  - apple_row/col <= idx, apple_valid <= 1, no_space <= 0, state <= IDLE.
- Latency:
  - Trigger sampled at edge N.
  - With the first candidate empty, wr_en is high between edges N+1 and N+2.
  - Each occupied probe adds one cycle.
  - Worst case: ROWS*COLS+1 cycles.
- Score:
  - Increments by 1 on the edge that samples eat_apple=1, in any state.
  - Holds at 2^SCORE_W-1.
  - start does not change score.
- eat_apple while busy:
  - Sets pending.
  - On return to IDLE, a set pending acts as a trigger and clears itself.
  - Only one pending is stored; further pulses while pending still add score.
- game_over=1:
  - No new trigger is accepted; eat_apple is ignored for score and pending.
  - An in-progress search is abandoned: state <= IDLE, no write, pending <= 0.
  - Outputs otherwise hold until reset.
- The eaten apple cell is overwritten by the snake head logic, not by this block.
- wr_en has no back-pressure; the grid must accept the write in that cycle.

Decomposition:
- Package `snake_pkg`:
  - cellStateColor enum (off=00, green=01, red=10, orange=11).
  - inputDirection enum.
  - GRID_ROWS/GRID_COLS constants.
  - spawner state enum {IDLE, PROBE, WRITE}.
- Sub-module `lfsr16`:
  - Parameter SEED; ports clk, reset, out[15:0].
  - Free-running; reused elsewhere for randomness.

Test Plan:
- Empty grid model, release reset with SEED=16'hACE1, then pulse start at edge N:
  - wr_en=1 one cycle later at wr_row=4'hE, wr_col=4'h1 (LFSR low byte as captured at edge N).
  - apple_valid=1, score=0.
- First candidate idx=0x20 and 0x21 orange, 0x22 off:
  - Exactly two extra PROBE cycles, then write at row 2, col 2.
  - Candidate 0xFF occupied wraps to probe 0x00.
- Three eat_apple pulses spaced ≥6 cycles apart:
  - score=3, three wr_en strobes, each to an off cell.
  - SCORE_W=2 with five pulses: score stays 3.
- All 256 cells non-off, then eat_apple:
  - 256 PROBE cycles, no wr_en, no_space=1, apple_valid=0.
- eat_apple twice during a long probe:
  - score +2, one pending search follows the current write, two writes total.
  - game_over asserted mid-PROBE: no wr_en, busy=0 next cycle; later eat_apple leaves score unchanged.
- reset driven low mid-PROBE (between edges):
  - All outputs go to reset values immediately.
  - After release, a start pulse behaves as in the first scenario.
